// File: rtl/tt_adder_pkg.sv
// Shared definitions for the byte-serial adder/accumulator tile.
// Holds the operation codes, the controller state encoding and the bit
// positions used on the bidirectional uio pins.
package tt_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SAT = 2'b10,
    OP_ACC = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // uio_in fields
  localparam int UIO_STRB   = 0;
  localparam int UIO_OP_LSB = 1;
  localparam int UIO_CLR    = 3;

  // uio_out fields
  localparam int UIO_BUSY  = 4;
  localparam int UIO_DONE  = 5;
  localparam int UIO_CARRY = 6;
  localparam int UIO_OVF   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_um_seq_adder_acc_byte_add_slice.sv
// One 8-bit adder slice, reused once per byte of the operand width.
// Ports:
//   a, b     8-bit addends
//   cin      carry into bit 0
//   sum      8-bit sum
//   cout     carry out of bit 7
//   msb_cin  carry into bit 7; XOR with cout gives signed overflow
module byte_add_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       msb_cin
);

  logic [7:0] low;
  logic [1:0] top;

  // Split at bit 7 so the carry into the sign bit is visible.
  assign low     = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
  assign msb_cin = low[7];
  assign top     = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, low[7]};
  assign sum     = {top[0], low[6:0]};
  assign cout    = top[1];

endmodule

// File: rtl/tt_um_seq_adder_acc.sv
// Byte-serial WIDTH-bit add / subtract / saturating add / accumulate tile.
// Operands arrive one byte per strobe edge (little-endian), the sum is formed
// one byte per clock through a single shared slice with a registered carry,
// and the result is read back one byte per strobe edge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         tile enable; low freezes controller, datapath and flags
//   ui_in       operand byte
//   uio_in      [0]=strobe, [2:1]=op, [3]=clear
//   uo_out      result byte at read pointer while DONE, else 0
//   uio_out     [4]=busy, [5]=done, [6]=carry/borrow, [7]=overflow
//   uio_oe      constant 8'hF0
module tt_um_seq_adder_acc
  import tt_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int BYTES = WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef logic [BYTES-1:0][7:0] word_t;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  word_t         a_q, a_d, b_q, b_d, r_q, r_d, acc_q, acc_d;
  logic [CW-1:0] bcnt_q, bcnt_d, rptr_q, rptr_d;
  logic          c_q, c_d, carry_q, carry_d, ovf_q, ovf_d;
  logic          strb_q;

  logic          stb, clr, last_byte;
  op_e           op_in;
  logic [7:0]    slice_a, slice_b, slice_sum;
  logic          slice_cout, slice_msb_cin;

  logic          unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:4]};

  assign stb       = uio_in[UIO_STRB] & ~strb_q;
  assign clr       = uio_in[UIO_CLR];
  assign op_in     = op_e'(uio_in[UIO_OP_LSB +: 2]);
  assign last_byte = (bcnt_q == CW'(BYTES - 1));

  // Second operand seen by the slice: inverted B (with cin=1) for subtract,
  // the accumulator for ACC, plain B otherwise.
  always_comb begin
    slice_a = a_q[bcnt_q];
    slice_b = b_q[bcnt_q];
    case (op_q)
      OP_SUB:  slice_b = ~b_q[bcnt_q];
      OP_ACC:  slice_b = acc_q[bcnt_q];
      default: slice_b = b_q[bcnt_q];
    endcase
  end

  byte_add_slice u_slice (
    .a       (slice_a),
    .b       (slice_b),
    .cin     (c_q),
    .sum     (slice_sum),
    .cout    (slice_cout),
    .msb_cin (slice_msb_cin)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    acc_d   = acc_q;
    bcnt_d  = bcnt_q;
    rptr_d  = rptr_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    if (clr) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      acc_d   = '0;
      bcnt_d  = '0;
      rptr_d  = '0;
      c_d     = 1'b0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (stb) begin
          op_d   = op_in;
          a_d[0] = ui_in;
          c_d    = (op_in == OP_SUB);
          if (BYTES == 1) begin
            bcnt_d  = '0;
            state_d = (op_in == OP_ACC) ? COMPUTE : LOAD_B;
          end else begin
            bcnt_d  = CW'(1);
            state_d = LOAD_A;
          end
        end
        LOAD_A: if (stb) begin
          a_d[bcnt_q] = ui_in;
          if (last_byte) begin
            bcnt_d  = '0;
            c_d     = 1'b0;
            state_d = (op_q == OP_ACC) ? COMPUTE : LOAD_B;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
        LOAD_B: if (stb) begin
          b_d[bcnt_q] = ui_in;
          if (last_byte) begin
            bcnt_d  = '0;
            c_d     = (op_q == OP_SUB);
            state_d = COMPUTE;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
        COMPUTE: begin
          r_d[bcnt_q] = slice_sum;
          c_d         = slice_cout;
          if (last_byte) begin
            bcnt_d  = '0;
            rptr_d  = '0;
            state_d = DONE;
            carry_d = (op_q == OP_SUB) ? ~slice_cout : slice_cout;
            ovf_d   = (op_q == OP_SAT) ? 1'b0 : (slice_msb_cin ^ slice_cout);
            if (op_q == OP_SAT && slice_cout) r_d = '1;
            if (op_q == OP_ACC) acc_d = r_d;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
        DONE: if (stb) begin
          if (rptr_q == CW'(BYTES - 1)) begin
            rptr_d  = '0;
            state_d = IDLE;
          end else begin
            rptr_d = rptr_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q  <= 1'b0;
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      bcnt_q  <= '0;
      rptr_q  <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // Strobe history tracks the pin even while disabled, so a strobe
      // held across a disable never turns into a stale edge later.
      strb_q <= uio_in[UIO_STRB];
      if (ena) begin
        state_q <= state_d;
        op_q    <= op_d;
        a_q     <= a_d;
        b_q     <= b_d;
        r_q     <= r_d;
        acc_q   <= acc_d;
        bcnt_q  <= bcnt_d;
        rptr_q  <= rptr_d;
        c_q     <= c_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  always_comb begin
    uo_out             = (state_q == DONE) ? r_q[rptr_q] : 8'h00;
    uio_out            = 8'h00;
    uio_out[UIO_BUSY]  = (state_q == COMPUTE);
    uio_out[UIO_DONE]  = (state_q == DONE);
    uio_out[UIO_CARRY] = carry_q;
    uio_out[UIO_OVF]   = ovf_q;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_seq_adder_acc.sv
module tb_tt_um_seq_adder_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, SAT = 2'b10, ACC = 2'b11;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  tt_um_seq_adder_acc #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: gathers result bytes and flags while done is high, compares on exit from DONE.
  logic        mon_prev = 1'b0;
  logic        in_done  = 1'b0;
  logic        stb_e;
  int          idx = 0;
  logic [15:0] res;
  logic        mc, mv;
  exp_t        e;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      in_done  = 1'b0;
      mon_prev = 1'b0;
    end else begin
      stb_e    = uio_in[0] & ~mon_prev;
      mon_prev = uio_in[0];
      if (in_done && stb_e) idx++;
      if (!in_done && uio_out[5]) begin
        in_done = 1'b1;
        idx     = 0;
        mc      = uio_out[6];
        mv      = uio_out[7];
      end
      if (in_done && uio_out[5]) begin
        if (idx == 0) res[7:0] = uo_out;
        else if (idx == 1) res[15:8] = uo_out;
      end else if (in_done && !uio_out[5]) begin
        in_done = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", {16'd0, res}, {16'd0, e.r});
          chk("carry", {31'd0, mc}, {31'd0, e.c});
          chk("ovf", {31'd0, mv}, {31'd0, e.v});
          chk("uo_out_after_read", {24'd0, uo_out}, 32'd0);
        end
      end
    end
  end

  task automatic send_byte(input logic [1:0] op, input logic [7:0] b);
    @(negedge clk);
    ui_in  = b;
    uio_in = {4'b0, 1'b0, op, 1'b1};
    @(negedge clk);
    uio_in[0] = 1'b0;
    ui_in     = 8'h5A;
  endtask

  task automatic do_clr();
    @(negedge clk);
    uio_in = 8'h08;
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!uio_out[5] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!uio_out[5]) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_out();
    send_byte(ADD, 8'h00);
    send_byte(ADD, 8'h00);
  endtask

  task automatic finish_op();
    int n;
    chk("busy_after_last_byte", {31'd0, uio_out[4]}, 32'd1);
    wait_done(n);
    chk("done_latency", n, 32'd2);
    read_out();
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic c, input logic v);
    sb.push_back('{r: r, c: c, v: v});
    send_byte(op, a[7:0]);
    send_byte(op, a[15:8]);
    if (op != ACC) begin
      send_byte(op, b[7:0]);
      send_byte(op, b[15:8]);
    end
    finish_op();
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_uo_out", {24'd0, uo_out}, 32'd0);
    chk("reset_uio_out", {24'd0, uio_out}, 32'd0);
    chk("reset_uio_oe", {24'd0, uio_oe}, 32'hF0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(ADD, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
    run_op(ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op(SUB, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);
    run_op(SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_op(SAT, 16'hFFF0, 16'h0020, 16'hFFFF, 1'b1, 1'b0);

    do_clr();
    chk("clr_flags", {24'd0, uio_out}, 32'd0);
    run_op(ACC, 16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b0);
    run_op(ACC, 16'h4000, 16'h0000, 16'h8000, 1'b0, 1'b1);
    run_op(ACC, 16'h4000, 16'h0000, 16'hC000, 1'b0, 1'b0);
    run_op(ACC, 16'h4000, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // clear after a single A byte
    send_byte(ADD, 8'h77);
    do_clr();
    chk("clr_mid_load_uio_out", {24'd0, uio_out}, 32'd0);
    chk("clr_mid_load_uo_out", {24'd0, uo_out}, 32'd0);
    run_op(ACC, 16'h0005, 16'h0000, 16'h0005, 1'b0, 1'b0);

    // strobe held high for several cycles counts as one byte
    sb.push_back('{r: 16'h0012, c: 1'b0, v: 1'b0});
    @(negedge clk);
    ui_in  = 8'h11;
    uio_in = 8'h01;
    @(negedge clk);
    ui_in = 8'h99;
    repeat (3) @(negedge clk);
    uio_in = 8'h00;
    send_byte(ADD, 8'h00);
    send_byte(ADD, 8'h01);
    send_byte(ADD, 8'h00);
    finish_op();

    // ena low in the middle of LOAD_B, with a strobe pulse while disabled
    sb.push_back('{r: 16'h0303, c: 1'b0, v: 1'b0});
    send_byte(ADD, 8'h00);
    send_byte(ADD, 8'h01);
    send_byte(ADD, 8'h03);
    @(negedge clk);
    ena       = 1'b0;
    ui_in     = 8'hEE;
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("ena_low_hold", {24'd0, uio_out}, 32'd0);
    ena = 1'b1;
    send_byte(ADD, 8'h02);
    finish_op();

    // strobe during COMPUTE is dropped
    sb.push_back('{r: 16'h0406, c: 1'b0, v: 1'b0});
    send_byte(ADD, 8'h02);
    send_byte(ADD, 8'h01);
    send_byte(ADD, 8'h04);
    send_byte(ADD, 8'h03);
    chk("busy_before_extra_stb", {31'd0, uio_out[4]}, 32'd1);
    send_byte(ADD, 8'hFF);
    wait_done(n);
    chk("done_after_extra_stb", n, 32'd0);
    read_out();

    // reset in the middle of COMPUTE
    send_byte(ADD, 8'h11);
    send_byte(ADD, 8'h22);
    send_byte(ADD, 8'h33);
    send_byte(ADD, 8'h44);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_compute_uo_out", {24'd0, uo_out}, 32'd0);
    chk("rst_mid_compute_uio_out", {24'd0, uio_out}, 32'd0);
    chk("rst_mid_compute_uio_oe", {24'd0, uio_oe}, 32'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(ADD, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
